bios_loader: RTL and testbench

Parametrised successor to the serial BIOS command block. Sits between the UART byte stream and the CPU's instruction/data RAM port. Decodes a byte-oriented command protocol to set a RAM address, stream full-width words into RAM, read words back LSB-first, pulse CPU reset and hand off to the CPU on boot. Generalised over address width, data width, RAM read latency and reset pulse length; addresses auto-increment.

---
 rtl/bios_loader.sv | 261 ++++++++++++++++++++++++++
 tb/tb_bios_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_loader.sv
// Byte-command BIOS loader between the UART byte stream and the CPU RAM port.
// Optional feature macro: BIOS_ACK_EN (one acknowledge byte per completed non-read command).
module bios_loader #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RST_CYCLES   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    output logic                    o_rst,
    output logic                    o_booted,
    output logic                    o_err,
    output logic                    o_read_req,
    output logic [ADDR_WIDTH-1:0]   o_read_addr,
    input  logic [DATA_WIDTH-1:0]   i_read_data,
    output logic                    o_write_enable,
    output logic [DATA_WIDTH/8-1:0] o_byte_enable,
    output logic [ADDR_WIDTH-1:0]   o_write_addr,
    output logic [DATA_WIDTH-1:0]   o_write_data,
    input  logic [7:0]              i_data,
    input  logic                    i_valid,
    output logic                    o_in_ready,
    output logic [7:0]              o_data,
    output logic                    o_valid,
    input  logic                    i_out_ready
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int NA = ADDR_WIDTH / 8;
    localparam int CW = 16;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_BOOT    = 8'h01;
    localparam logic [7:0] OP_RST     = 8'h02;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_WRITE   = 8'h04;
    localparam logic [7:0] OP_SETADDR = 8'h05;
    localparam logic [7:0] ACK_UNKNOWN = 8'hFF;

`ifdef BIOS_ACK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RSEND, RSTP, ACK, BOOTED
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   booted_q, booted_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic                   rstp_q, rstp_d;
    logic                   in_ready_s;
    logic                   in_fire_s;
    logic                   out_fire_s;
    logic                   go_done_s;
    logic [7:0]             ack_s;

    // Ready is gated by rst so the port reads 0 during reset and 1 right after.
    assign in_ready_s = ~rst & ((state_q == IDLE) | (state_q == ADDR) | (state_q == WDATA));
    assign in_fire_s  = i_valid & in_ready_s;
    assign out_fire_s = valid_q & i_out_ready;

    // Next-state and datapath decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
        booted_d  = booted_q;
        go_done_s = 1'b0;
        ack_s     = OP_NOP;

        case (state_q)
            IDLE: begin
                if (in_fire_s) begin
                    cnt_d = '0;
                    case (i_data)
                        OP_NOP: begin
                            go_done_s = 1'b1;
                            ack_s     = OP_NOP;
                        end
                        OP_BOOT: begin
                            state_d  = BOOTED;
                            booted_d = 1'b1;
                        end
                        OP_RST:     state_d = RSTP;
                        OP_READ:    state_d = RREQ;
                        OP_WRITE:   state_d = WDATA;
                        OP_SETADDR: state_d = ADDR;
                        default: begin
                            err_d     = 1'b1;
                            go_done_s = 1'b1;
                            ack_s     = ACK_UNKNOWN;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                // Bytes shift in from the top so byte 0 lands in bits 7:0 after NA bytes.
                if (in_fire_s) begin
                    addr_d = (addr_q >> 8) | (ADDR_WIDTH'(i_data) << (ADDR_WIDTH - 8));
                    if (cnt_q == CW'(NA - 1)) begin
                        cnt_d     = '0;
                        go_done_s = 1'b1;
                        ack_s     = OP_SETADDR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ADDR;
                end
            end
            WDATA: begin
                if (in_fire_s) begin
                    wdata_d = (wdata_q >> 8) | (DATA_WIDTH'(i_data) << (DATA_WIDTH - 8));
                    if (cnt_q == CW'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = WDATA;
                end
            end
            WRITE: begin
                addr_d    = addr_q + ADDR_WIDTH'(NB);
                go_done_s = 1'b1;
                ack_s     = OP_WRITE;
            end
            RREQ: begin
                cnt_d   = '0;
                state_d = RWAIT;
            end
            RWAIT: begin
                if (cnt_q == CW'(READ_LATENCY - 1)) begin
                    cnt_d   = '0;
                    data_d  = i_read_data[7:0];
                    rdata_d = i_read_data >> 8;
                    valid_d = 1'b1;
                    state_d = RSEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RSEND: begin
                if (out_fire_s) begin
                    if (cnt_q == CW'(NB - 1)) begin
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        addr_d  = addr_q + ADDR_WIDTH'(NB);
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        data_d  = rdata_q[7:0];
                        rdata_d = rdata_q >> 8;
                    end
                end else begin
                    state_d = RSEND;
                end
            end
            RSTP: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    cnt_d     = '0;
                    go_done_s = 1'b1;
                    ack_s     = OP_RST;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK: begin
                if (out_fire_s) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            BOOTED:  state_d = BOOTED;
            default: state_d = IDLE;
        endcase

        if (go_done_s && ACK_EN) begin
            state_d = ACK;
            data_d  = ack_s;
            valid_d = 1'b1;
        end else if (go_done_s) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end

        we_d   = (state_d == WRITE);
        re_d   = (state_d == RREQ);
        rstp_d = (state_d == RSTP);
    end

    // State and output registers; nothing moves on cycles with clk_en low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            booted_q <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            rstp_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            booted_q <= booted_d;
            we_q     <= we_d;
            re_q     <= re_d;
            rstp_q   <= rstp_d;
        end
    end

    // Strobe flags are masked by clk_en so each lasts exactly one enabled cycle.
    assign o_write_enable = we_q & clk_en;
    assign o_read_req     = re_q & clk_en;
    assign o_byte_enable  = {NB{o_write_enable}};
    assign o_rst          = rstp_q & ~rst;
    assign o_booted       = booted_q;
    assign o_err          = err_q;
    assign o_read_addr    = addr_q;
    assign o_write_addr   = addr_q;
    assign o_write_data   = wdata_q;
    assign o_in_ready     = in_ready_s;
    assign o_data         = data_q;
    assign o_valid        = valid_q;

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader (32-bit address/data, READ_LATENCY=2, RST_CYCLES=4).
module tb_bios_loader;

    localparam int LAT = 2;
`ifdef BIOS_ACK_EN
    localparam int ACKN = 1;
`else
    localparam int ACKN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        toggle_en = 1'b0;
    logic        o_rst, o_booted, o_err, o_read_req, o_write_enable;
    logic [31:0] o_read_addr, o_write_addr, o_write_data, i_read_data;
    logic [3:0]  o_byte_enable;
    logic [7:0]  i_data = 8'h00;
    logic        i_valid = 1'b0;
    logic        o_in_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_out_ready = 1'b1;

    logic [LAT-1:0] rd_pipe;
    logic [31:0]    ram_word = 32'h0;
    logic [31:0]    ra_last = 32'h0;
    int             rd_reqs = 0;
    int             rst_clks = 0;
    int             rst_en = 0;
    logic [31:0]    wa_q[$];
    logic [31:0]    wd_q[$];
    logic [3:0]     wb_q[$];
    logic [7:0]     resp_q[$];

    int total = 0;
    int bad = 0;

    bios_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(LAT), .RST_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .o_rst(o_rst), .o_booted(o_booted), .o_err(o_err),
        .o_read_req(o_read_req), .o_read_addr(o_read_addr), .i_read_data(i_read_data),
        .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
        .o_write_addr(o_write_addr), .o_write_data(o_write_data),
        .i_data(i_data), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    // clk_en changes shortly after each rising edge: steady 1, or alternating.
    always @(posedge clk) begin
        #2 clk_en = toggle_en ? ~clk_en : 1'b1;
    end

    // RAM returns ram_word only in the cycle exactly LAT enabled cycles after the request.
    assign i_read_data = rd_pipe[LAT-1] ? ram_word : 32'h0BAD_F00D;

    always @(posedge clk) begin
        if (rst) rd_pipe <= '0;
        else if (clk_en) rd_pipe <= {rd_pipe[LAT-2:0], o_read_req};
        if (o_write_enable === 1'b1) begin
            wa_q.push_back(o_write_addr);
            wd_q.push_back(o_write_data);
            wb_q.push_back(o_byte_enable);
        end
        if (o_read_req === 1'b1) begin
            rd_reqs <= rd_reqs + 1;
            ra_last <= o_read_addr;
        end
        if (o_valid === 1'b1 && i_out_ready && clk_en) resp_q.push_back(o_data);
        if (o_rst === 1'b1) begin
            rst_clks <= rst_clks + 1;
            if (clk_en) rst_en <= rst_en + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        i_data  = b;
        i_valid = 1'b1;
        while (!(o_in_ready === 1'b1 && clk_en) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL send_timeout byte=%02h not accepted within 100 cycles", b);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic send5(input logic [7:0] a, input logic [31:0] w);
        send_byte(a);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", o_in_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", o_in_ready); end
        total++;
        if ({o_rst, o_booted, o_err, o_valid, o_write_enable, o_read_req} !== 6'b0) begin
            bad++; $display("FAIL rst_flags got=%b want=000000", {o_rst, o_booted, o_err, o_valid, o_write_enable, o_read_req});
        end
        total++;
        if (o_data !== 8'h00 || o_write_data !== 32'h0 || o_read_addr !== 32'h0) begin
            bad++; $display("FAIL rst_regs data=%h wdata=%h addr=%h want all 0", o_data, o_write_data, o_read_addr);
        end
    endtask

    task automatic test_write;
        int wb, rb;
        wb = wa_q.size(); rb = resp_q.size();
        send5(8'h05, 32'h0000_0010);
        send5(8'h04, 32'hDEAD_BEEF);
        total++; if (o_write_enable !== 1'b1) begin bad++; $display("FAIL write_strobe_timing got=%b want=1", o_write_enable); end
        @(negedge clk);
        total++; if (o_write_enable !== 1'b0) begin bad++; $display("FAIL write_strobe_width got=%b want=0", o_write_enable); end
        repeat (2) @(negedge clk);
        total++;
        if (wa_q.size() != wb + 1) begin
            bad++; $display("FAIL write_count got=%0d want=1", wa_q.size() - wb);
        end else if (wa_q[wb] !== 32'h10 || wd_q[wb] !== 32'hDEADBEEF || wb_q[wb] !== 4'hF) begin
            bad++; $display("FAIL write_word got a=%h d=%h be=%h want a=10 d=deadbeef be=f", wa_q[wb], wd_q[wb], wb_q[wb]);
        end
        total++; if (o_write_addr !== 32'h14) begin bad++; $display("FAIL write_incr got=%h want=00000014", o_write_addr); end
        total++; if (resp_q.size() - rb != 2 * ACKN) begin bad++; $display("FAIL write_resp_count got=%0d want=%0d", resp_q.size() - rb, 2 * ACKN); end
    endtask

    task automatic test_read;
        int n, rb, qb;
        logic [31:0] got;
        send5(8'h05, 32'h0000_0010);
        repeat (2) @(negedge clk);
        ram_word = 32'hDEAD_BEEF;
        qb = rd_reqs;
        rb = resp_q.size();
        i_out_ready = 1'b0;
        send_byte(8'h03);
        n = 0;
        while (o_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++; if (n != LAT + 1) begin bad++; $display("FAIL read_latency got=%0d want=%0d", n, LAT + 1); end
        total++; if (o_data !== 8'hEF) begin bad++; $display("FAIL read_byte0 got=%h want=ef", o_data); end
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (o_data !== 8'hBE || o_valid !== 1'b1) begin
            bad++; $display("FAIL read_stall got data=%h valid=%b want be/1", o_data, o_valid);
        end
        i_out_ready = 1'b1;
        n = 0;
        while (o_valid === 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (resp_q.size() - rb != 4) begin
            bad++; $display("FAIL read_count got=%0d want=4", resp_q.size() - rb);
        end else begin
            got = {resp_q[rb+3], resp_q[rb+2], resp_q[rb+1], resp_q[rb]};
            if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL read_bytes got=%h want=deadbeef (lsb first)", got); end
        end
        total++;
        if (rd_reqs - qb != 1 || ra_last !== 32'h10) begin
            bad++; $display("FAIL read_req got n=%0d a=%h want 1/00000010", rd_reqs - qb, ra_last);
        end
        total++; if (o_read_addr !== 32'h14) begin bad++; $display("FAIL read_incr got=%h want=00000014", o_read_addr); end
    endtask

    task automatic test_wrap;
        int wb;
        wb = wa_q.size();
        send5(8'h05, 32'hFFFF_FFFC);
        send5(8'h04, 32'h4433_2211);
        send5(8'h04, 32'h8877_6655);
        repeat (3) @(negedge clk);
        total++;
        if (wa_q.size() != wb + 2) begin
            bad++; $display("FAIL wrap_count got=%0d want=2", wa_q.size() - wb);
        end else if (wa_q[wb] !== 32'hFFFFFFFC || wd_q[wb] !== 32'h44332211 ||
                     wa_q[wb+1] !== 32'h0 || wd_q[wb+1] !== 32'h88776655) begin
            bad++; $display("FAIL wrap_addr got %h:%h %h:%h want fffffffc:44332211 00000000:88776655",
                            wa_q[wb], wd_q[wb], wa_q[wb+1], wd_q[wb+1]);
        end
        total++; if (o_write_addr !== 32'h4) begin bad++; $display("FAIL wrap_incr got=%h want=00000004", o_write_addr); end
    endtask

    task automatic test_rst_pulse;
        int c0, e0, n;
        toggle_en = 1'b1;
        repeat (2) @(negedge clk);
        c0 = rst_clks; e0 = rst_en;
        send_byte(8'h02);
        total++; if (o_rst !== 1'b1) begin bad++; $display("FAIL rstp_start got=%b want=1", o_rst); end
        n = 0;
        while (o_rst === 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (rst_clks - c0 != 8 || rst_en - e0 != 4) begin
            bad++; $display("FAIL rstp_len got clocks=%0d enabled=%0d want 8/4", rst_clks - c0, rst_en - e0);
        end
        toggle_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_err;
        int wb, qb, rb;
        wb = wa_q.size(); qb = rd_reqs; rb = resp_q.size();
        send_byte(8'h7E);
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", o_err); end
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        total++;
        if (wa_q.size() != wb || rd_reqs != qb || o_err !== 1'b1) begin
            bad++; $display("FAIL err_side got writes=%0d reads=%0d err=%b want 0/0/1", wa_q.size() - wb, rd_reqs - qb, o_err);
        end
        total++; if (resp_q.size() - rb != 2 * ACKN) begin bad++; $display("FAIL err_resp_count got=%0d want=%0d", resp_q.size() - rb, 2 * ACKN); end
`ifdef BIOS_ACK_EN
        total++;
        if (resp_q.size() - rb == 2 && (resp_q[rb] !== 8'hFF || resp_q[rb+1] !== 8'h00)) begin
            bad++; $display("FAIL err_ack_bytes got=%h %h want=ff 00", resp_q[rb], resp_q[rb+1]);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int wb;
        wb = wa_q.size();
        send5(8'h05, 32'h0000_0020);
        total++; if (o_in_ready !== 1'b1 - 1'(ACKN)) begin bad++; $display("FAIL b2b_after_addr got=%b want=%0d", o_in_ready, 1 - ACKN); end
        send5(8'h04, 32'h0403_0201);
        total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_write got=%b want=0", o_in_ready); end
        @(negedge clk);
        total++; if (o_in_ready !== 1'b1 - 1'(ACKN)) begin bad++; $display("FAIL b2b_after_write got=%b want=%0d", o_in_ready, 1 - ACKN); end
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        total++;
        if (wa_q.size() != wb + 1 || wa_q[wa_q.size()-1] !== 32'h20 || wd_q[wd_q.size()-1] !== 32'h04030201) begin
            bad++; $display("FAIL b2b_write got n=%0d want one write 04030201 at 00000020", wa_q.size() - wb);
        end
    endtask

    task automatic test_boot_and_rst;
        int wb;
        send_byte(8'h01);
        total++; if (o_booted !== 1'b1 || o_in_ready !== 1'b0) begin bad++; $display("FAIL boot got booted=%b ready=%b want 1/0", o_booted, o_in_ready); end
        repeat (4) @(negedge clk);
        total++; if (o_booted !== 1'b1 || o_in_ready !== 1'b0 || o_valid !== 1'b0) begin bad++; $display("FAIL boot_sticky got booted=%b ready=%b valid=%b want 1/0/0", o_booted, o_in_ready, o_valid); end
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        total++; if (o_booted !== 1'b0 || o_in_ready !== 1'b1) begin bad++; $display("FAIL boot_rst got booted=%b ready=%b want 0/1", o_booted, o_in_ready); end
        wb = wa_q.size();
        send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (wa_q.size() != wb || o_write_data !== 32'h0 || o_write_addr !== 32'h0 || o_in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_wdata got writes=%0d wdata=%h addr=%h ready=%b want 0/0/0/1",
                            wa_q.size() - wb, o_write_data, o_write_addr, o_in_ready);
        end
        send_byte(8'h02);
        @(negedge clk);
        rst = 1'b1; @(negedge clk);
        total++; if (o_rst !== 1'b0) begin bad++; $display("FAIL rst_mid_rstp got=%b want=0", o_rst); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_rst_pulse();
        test_err();
        test_back_to_back();
        test_boot_and_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
